// File: rtl/debounce_arbiter.sv
// debounce_arbiter
// Time-shared debounce controller. A single stability counter is handed out
// round-robin to whichever button currently disagrees with its debounced level.
// The owner must hold its new level for 2^CNT_W consecutive edges to commit.
// Any change during that window aborts the attempt and frees the counter.
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous, active-high
//   btn_raw    synchronized raw button levels
//   btn_db     registered debounced levels
//   btn_pulse  one-cycle pulse on a committed 0->1 transition
//   grant_oh   one-hot owner of the counter, zero when idle
//   busy       high while counting or holding
//   abort_cnt  saturating abort count (only with DEBOUNCE_ABORT_CNT_EN)
//
// Optional feature macro: DEBOUNCE_ABORT_CNT_EN
module debounce_arbiter #(
    parameter int N_BTN = 4,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_db,
    output logic [N_BTN-1:0] btn_pulse,
    output logic [N_BTN-1:0] grant_oh,
    output logic             busy
`ifdef DEBOUNCE_ABORT_CNT_EN
    ,
    output logic [7:0]       abort_cnt
`endif
);

    localparam int          IW = (N_BTN > 1) ? $clog2(N_BTN) : 1;
    localparam int unsigned NB = N_BTN;

    typedef enum logic [1:0] {
        IDLE,
        COUNT,
        HOLD
    } state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [IW-1:0]    g, g_n;
    logic [IW-1:0]    last, last_n;
    logic             target, target_n;
    logic [N_BTN-1:0] db_n, pulse_n, grant_n;
    logic             busy_n;

    logic [N_BTN-1:0] req;
    logic             rr_found;
    logic [IW-1:0]    rr_idx;

    assign req = btn_raw ^ btn_db;

    // Round-robin search starting one past the last granted index.
    always_comb begin
        int unsigned cand;
        logic [IW-1:0] cand_i;
        rr_found = 1'b0;
        rr_idx   = '0;
        cand     = 0;
        cand_i   = '0;
        for (int unsigned k = 1; k <= NB; k++) begin
            cand   = (32'(last) + k) % NB;
            cand_i = IW'(cand);
            if (!rr_found && req[cand_i]) begin
                rr_found = 1'b1;
                rr_idx   = cand_i;
            end
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        g_n      = g;
        last_n   = last;
        target_n = target;
        db_n     = btn_db;
        pulse_n  = btn_pulse;
        grant_n  = grant_oh;
        busy_n   = busy;
        case (state)
            IDLE: begin
                if (rr_found) begin
                    g_n      = rr_idx;
                    last_n   = rr_idx;
                    target_n = btn_raw[rr_idx];
                    cnt_n    = '0;
                    grant_n  = N_BTN'(1) << rr_idx;
                    busy_n   = 1'b1;
                    state_n  = COUNT;
                end
            end
            COUNT: begin
                if (btn_raw[g] != target) begin
                    cnt_n   = '0;
                    grant_n = '0;
                    busy_n  = 1'b0;
                    state_n = IDLE;
                end else if (cnt == '1) begin
                    db_n[g]    = target;
                    pulse_n[g] = target;
                    state_n    = HOLD;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            HOLD: begin
                pulse_n = '0;
                grant_n = '0;
                busy_n  = 1'b0;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            g         <= '0;
            last      <= IW'(N_BTN - 1);
            target    <= 1'b0;
            btn_db    <= '0;
            btn_pulse <= '0;
            grant_oh  <= '0;
            busy      <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            g         <= g_n;
            last      <= last_n;
            target    <= target_n;
            btn_db    <= db_n;
            btn_pulse <= pulse_n;
            grant_oh  <= grant_n;
            busy      <= busy_n;
        end
    end

`ifdef DEBOUNCE_ABORT_CNT_EN
    logic abort_ev;

    assign abort_ev = (state == COUNT) && (btn_raw[g] != target);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            abort_cnt <= '0;
        end else if (abort_ev && (abort_cnt != 8'hFF)) begin
            abort_cnt <= abort_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_debounce_arbiter.sv
// Testbench for debounce_arbiter at default parameters (N_BTN=4, CNT_W=6).
// Directed table, hand-written corner sequences, then random stimulus
// compared against a window-level reference model.
module tb_debounce_arbiter;

    logic       clk;
    logic       reset;
    logic [3:0] btn_raw;
    logic [3:0] btn_db;
    logic [3:0] btn_pulse;
    logic [3:0] grant_oh;
    logic       busy;
`ifdef DEBOUNCE_ABORT_CNT_EN
    logic [7:0] abort_cnt;
`endif

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    debounce_arbiter #(.N_BTN(4), .CNT_W(6)) dut (
        .clk       (clk),
        .reset     (reset),
        .btn_raw   (btn_raw),
        .btn_db    (btn_db),
        .btn_pulse (btn_pulse),
        .grant_oh  (grant_oh),
        .busy      (busy)
`ifdef DEBOUNCE_ABORT_CNT_EN
        ,
        .abort_cnt (abort_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: one window per grant, tracked by edges since grant.
    int         m_owner;
    int         m_age;
    int         m_last;
    int         m_abort;
    logic       m_tgt;
    logic [3:0] m_db, m_pulse, m_grant;
    logic       m_busy;

    task automatic model_reset();
        m_owner = -1;
        m_age   = 0;
        m_last  = 3;
        m_abort = 0;
        m_tgt   = 1'b0;
        m_db    = '0;
        m_pulse = '0;
        m_grant = '0;
        m_busy  = 1'b0;
    endtask

    task automatic model_step(input logic [3:0] raw);
        logic [3:0] req;
        bit found;
        if (m_owner < 0) begin
            req   = raw ^ m_db;
            found = 0;
            for (int k = 1; k <= 4; k++) begin
                int c;
                c = (m_last + k) % 4;
                if (!found && req[c]) begin
                    found   = 1;
                    m_owner = c;
                end
            end
            if (found) begin
                m_last  = m_owner;
                m_tgt   = raw[m_owner];
                m_age   = 0;
                m_grant = 4'b0001 << m_owner;
                m_busy  = 1'b1;
            end
        end else begin
            m_age++;
            if (m_age == 65) begin
                m_pulse = '0;
                m_owner = -1;
                m_grant = '0;
                m_busy  = 1'b0;
            end else if (raw[m_owner] != m_tgt) begin
                m_owner = -1;
                m_grant = '0;
                m_busy  = 1'b0;
                if (m_abort < 255) m_abort++;
            end else if (m_age == 64) begin
                m_db[m_owner]    = m_tgt;
                m_pulse[m_owner] = m_tgt;
            end
        end
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        btn_raw = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    typedef struct {
        logic [3:0] raw;
        int         cycles;
        logic [3:0] db;
        logic [3:0] pulse;
        logic [3:0] grant;
        logic       busy;
        int         ab;
    } vec_t;

    vec_t tbl[22];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset   = 1'b1;
        btn_raw = '0;
        #3;
        chk("reset_db", btn_db, 4'b0000);
        chk("reset_pulse", btn_pulse, 4'b0000);
        chk("reset_grant", grant_oh, 4'b0000);
        chk("reset_busy", busy, 1'b0);
`ifdef DEBOUNCE_ABORT_CNT_EN
        chk("reset_abort", abort_cnt, 8'd0);
`endif

        // raw, cycles, db, pulse, grant, busy, aborts
        tbl[0]  = '{4'b0001,  1, 4'b0000, 4'b0000, 4'b0001, 1'b1, 0};
        tbl[1]  = '{4'b0001, 63, 4'b0000, 4'b0000, 4'b0001, 1'b1, 0};
        tbl[2]  = '{4'b0001,  1, 4'b0001, 4'b0001, 4'b0001, 1'b1, 0};
        tbl[3]  = '{4'b0001,  1, 4'b0001, 4'b0000, 4'b0000, 1'b0, 0};
        tbl[4]  = '{4'b0011,  1, 4'b0001, 4'b0000, 4'b0010, 1'b1, 0};
        tbl[5]  = '{4'b0011, 20, 4'b0001, 4'b0000, 4'b0010, 1'b1, 0};
        tbl[6]  = '{4'b0001,  1, 4'b0001, 4'b0000, 4'b0000, 1'b0, 1};
        tbl[7]  = '{4'b0001,  3, 4'b0001, 4'b0000, 4'b0000, 1'b0, 1};
        tbl[8]  = '{4'b0000,  1, 4'b0001, 4'b0000, 4'b0001, 1'b1, 1};
        tbl[9]  = '{4'b0000, 63, 4'b0001, 4'b0000, 4'b0001, 1'b1, 1};
        tbl[10] = '{4'b0000,  1, 4'b0000, 4'b0000, 4'b0001, 1'b1, 1};
        tbl[11] = '{4'b0000,  1, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1};
        tbl[12] = '{4'b1101,  1, 4'b0000, 4'b0000, 4'b0100, 1'b1, 1};
        tbl[13] = '{4'b1101, 63, 4'b0000, 4'b0000, 4'b0100, 1'b1, 1};
        tbl[14] = '{4'b1101,  1, 4'b0100, 4'b0100, 4'b0100, 1'b1, 1};
        tbl[15] = '{4'b1101,  1, 4'b0100, 4'b0000, 4'b0000, 1'b0, 1};
        tbl[16] = '{4'b1101,  1, 4'b0100, 4'b0000, 4'b1000, 1'b1, 1};
        tbl[17] = '{4'b1101, 64, 4'b1100, 4'b1000, 4'b1000, 1'b1, 1};
        tbl[18] = '{4'b1101,  1, 4'b1100, 4'b0000, 4'b0000, 1'b0, 1};
        tbl[19] = '{4'b1101,  1, 4'b1100, 4'b0000, 4'b0001, 1'b1, 1};
        tbl[20] = '{4'b1101, 64, 4'b1101, 4'b0001, 4'b0001, 1'b1, 1};
        tbl[21] = '{4'b1101,  1, 4'b1101, 4'b0000, 4'b0000, 1'b0, 1};

        do_reset();
        for (int i = 0; i < 22; i++) begin
            @(negedge clk);
            btn_raw = tbl[i].raw;
            repeat (tbl[i].cycles) @(posedge clk);
            #1;
            chk($sformatf("tbl%0d_db", i), btn_db, tbl[i].db);
            chk($sformatf("tbl%0d_pulse", i), btn_pulse, tbl[i].pulse);
            chk($sformatf("tbl%0d_grant", i), grant_oh, tbl[i].grant);
            chk($sformatf("tbl%0d_busy", i), busy, tbl[i].busy);
`ifdef DEBOUNCE_ABORT_CNT_EN
            chk($sformatf("tbl%0d_abort", i), abort_cnt, 8'(tbl[i].ab));
`endif
        end

        // Simultaneous requests from reset: order 0, 2, 3, 66 edges apart.
        do_reset();
        @(negedge clk);
        btn_raw = 4'b1101;
        begin
            int order[3];
            int prev;
            order = '{0, 2, 3};
            prev  = 0;
            for (int n = 0; n < 3; n++) begin
                int t;
                t = 0;
                do begin
                    @(posedge clk);
                    #1;
                    t++;
                end while (grant_oh == 4'b0000 && t < 200);
                chk($sformatf("simul%0d_grant", n), grant_oh, 4'b0001 << order[n]);
                if (n > 0) chk($sformatf("simul%0d_spacing", n), cyc - prev, 66);
                prev = cyc;
                repeat (63) @(posedge clk);
                #1;
                chk($sformatf("simul%0d_prepulse", n), btn_pulse, 4'b0000);
                @(posedge clk);
                #1;
                chk($sformatf("simul%0d_pulse", n), btn_pulse, 4'b0001 << order[n]);
                @(posedge clk);
                #1;
                chk($sformatf("simul%0d_pulse_clr", n), btn_pulse, 4'b0000);
            end
            chk("simul_db", btn_db, 4'b1101);
        end

        // Asynchronous reset in the middle of a window, then a fresh window.
        do_reset();
        @(negedge clk);
        btn_raw = 4'b0001;
        repeat (31) @(posedge clk);
        #1;
        chk("midrst_busy_before", busy, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        chk("midrst_db", btn_db, 4'b0000);
        chk("midrst_pulse", btn_pulse, 4'b0000);
        chk("midrst_grant", grant_oh, 4'b0000);
        chk("midrst_busy", busy, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        repeat (64) @(posedge clk);
        #1;
        chk("midrst_e63_db", btn_db, 4'b0000);
        chk("midrst_e63_grant", grant_oh, 4'b0001);
        @(posedge clk);
        #1;
        chk("midrst_e64_db", btn_db, 4'b0001);
        chk("midrst_e64_pulse", btn_pulse, 4'b0001);

`ifdef DEBOUNCE_ABORT_CNT_EN
        // Repeated single-edge aborts drive the counter into saturation.
        do_reset();
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            btn_raw = 4'b0001;
            @(negedge clk);
            btn_raw = 4'b0000;
            if (i == 1) chk("sat_first_abort", abort_cnt, 8'd1);
        end
        @(posedge clk);
        #1;
        chk("sat_abort", abort_cnt, 8'd255);
        chk("sat_db", btn_db, 4'b0000);
`endif

        // Random stimulus against the reference model.
        do_reset();
        begin
            int den;
            den = 400;
            for (int i = 0; i < 4000; i++) begin
                logic [3:0] mask;
                if (i % 500 == 0) den = ((i / 500) % 2 == 1) ? 20 : 400;
                @(negedge clk);
                mask = '0;
                for (int b = 0; b < 4; b++)
                    if ($urandom_range(den - 1, 0) == 0) mask[b] = 1'b1;
                btn_raw = btn_raw ^ mask;
                @(posedge clk);
                model_step(btn_raw);
                #1;
                chk("rand_db", btn_db, m_db);
                chk("rand_pulse", btn_pulse, m_pulse);
                chk("rand_grant", grant_oh, m_grant);
                chk("rand_busy", busy, m_busy);
`ifdef DEBOUNCE_ABORT_CNT_EN
                chk("rand_abort", abort_cnt, 8'(m_abort));
`endif
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
